// File: rtl/dev_bus_arbiter.sv
// Peripheral bus arbiter: two requesters (CPU MEM, debug/DMA) share timer0/timer1.
// Round-robin grant, address decode, device req/ack with timeout, CPU stall.
module dev_bus_arbiter #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_7f00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7f10,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic        dev_req,
  output logic [1:0]  dev_sel,
  output logic        dev_we,
  output logic [1:0]  dev_addr,
  output logic [31:0] dev_wdata,
  input  logic [31:0] dev0_rdata,
  input  logic        dev0_ack,
  input  logic [31:0] dev1_rdata,
  input  logic        dev1_ack,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0]  TMO = 8'(TIMEOUT);
  localparam logic [31:0] WIN = 32'd12;

  state_t      state;
  state_t      state_d;
  logic        gnt;
  logic        last_grant;
  logic        lat_we;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;

  logic        any_req;
  logic        gnt_d;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] off0;
  logic [31:0] off1;
  logic        in0;
  logic        in1;
  logic [1:0]  w_off;
  logic [1:0]  w_sel;
  logic        legal;

  logic        ack_sel;
  logic [31:0] sel_rdata;
  logic        tmo;
  logic        issue_go;
  logic        dev_end;
  logic        resp_v;
  logic        resp_port;
  logic        resp_err;
  logic [31:0] resp_rdata;

  assign stall   = m0_req & ~m0_done;
  assign any_req = m0_req | m1_req;
  assign cnt_inc = cnt + 8'd1;

  // Unsigned offset: addresses below a base wrap to huge
  // values, so one compare covers both window edges.
  assign off0 = w_addr - DEV0_BASE;
  assign off1 = w_addr - DEV1_BASE;

  always_comb begin
    gnt_d = m1_req;
    if (m0_req && m1_req) begin
      gnt_d = ~last_grant;
    end
    w_we    = gnt_d ? m1_we    : m0_we;
    w_addr  = gnt_d ? m1_addr  : m0_addr;
    w_wdata = gnt_d ? m1_wdata : m0_wdata;
    in0     = off0 < WIN;
    in1     = off1 < WIN;
    w_off   = in0 ? off0[3:2] : off1[3:2];
    w_sel   = in0 ? 2'b01 : 2'b10;
    // COUNT (offset 8) is read-only.
    legal   = (w_addr[1:0] == 2'b00) && (in0 || in1) &&
              !(w_we && (w_off == 2'd2));
  end

  always_comb begin
    ack_sel   = (dev_sel[0] & dev0_ack) |
                (dev_sel[1] & dev1_ack);
    sel_rdata = dev_sel[0] ? dev0_rdata : dev1_rdata;
    tmo       = (cnt_inc == TMO);
  end

  always_comb begin
    state_d    = state;
    issue_go   = 1'b0;
    dev_end    = 1'b0;
    resp_v     = 1'b0;
    resp_port  = gnt;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          resp_port = gnt_d;
          if (legal) begin
            issue_go = 1'b1;
            state_d  = ISSUE;
          end else begin
            resp_v   = 1'b1;
            resp_err = 1'b1;
            state_d  = RESP;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Ack beats a timeout in the same cycle.
        if (ack_sel) begin
          dev_end = 1'b1;
          resp_v  = 1'b1;
          if (!lat_we) begin
            resp_rdata = sel_rdata;
          end
          state_d = RESP;
        end else if (tmo) begin
          dev_end  = 1'b1;
          resp_v   = 1'b1;
          resp_err = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      cnt        <= 8'd0;
      dev_req    <= 1'b0;
      dev_sel    <= 2'b00;
      dev_we     <= 1'b0;
      dev_addr   <= 2'd0;
      dev_wdata  <= 32'h0;
      m0_done    <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= 32'h0;
      m1_done    <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= 32'h0;
    end else begin
      m0_done <= 1'b0;
      m0_err  <= 1'b0;
      m1_done <= 1'b0;
      m1_err  <= 1'b0;
      if (state == IDLE && any_req) begin
        gnt        <= gnt_d;
        last_grant <= gnt_d;
        lat_we     <= w_we;
      end
      if (issue_go) begin
        dev_req   <= 1'b1;
        dev_sel   <= w_sel;
        dev_we    <= w_we;
        dev_addr  <= w_off;
        dev_wdata <= w_wdata;
      end
      if (state == ISSUE) begin
        cnt <= 8'd0;
      end
      if (state == WAIT) begin
        cnt <= cnt_inc;
      end
      if (dev_end) begin
        dev_req <= 1'b0;
        dev_sel <= 2'b00;
        dev_we  <= 1'b0;
      end
      if (resp_v) begin
        if (resp_port) begin
          m1_done  <= 1'b1;
          m1_err   <= resp_err;
          m1_rdata <= resp_rdata;
        end else begin
          m0_done  <= 1'b1;
          m0_err   <= resp_err;
          m0_rdata <= resp_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Bench for dev_bus_arbiter: schedule-based transaction model
// checked every cycle, plus literal latency/data pins.
module tb_dev_bus_arbiter;

  localparam int MAXC = 1024;
  localparam int TMO  = 15;
  localparam logic [31:0] B0 = 32'h7f00;
  localparam logic [31:0] B1 = 32'h7f10;

  logic clk = 1'b0;
  logic reset;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic m0_done, m0_err, m1_done, m1_err;
  logic dev_req, dev_we;
  logic [1:0] dev_sel, dev_addr;
  logic [31:0] dev_wdata, dev0_rdata, dev1_rdata;
  logic dev0_ack, dev1_ack, stall;

  always #5 clk = ~clk;

  dev_bus_arbiter #(
    .DEV0_BASE(B0), .DEV1_BASE(B1), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .m1_done(m1_done), .m1_err(m1_err),
    .dev_req(dev_req), .dev_sel(dev_sel), .dev_we(dev_we),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev0_rdata(dev0_rdata), .dev0_ack(dev0_ack),
    .dev1_rdata(dev1_rdata), .dev1_ack(dev1_ack),
    .stall(stall)
  );

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  int mlast;

  bit          e_dreq [MAXC];
  logic [1:0]  e_sel  [MAXC];
  logic [1:0]  e_addr [MAXC];
  bit          e_we   [MAXC];
  logic [31:0] e_wd   [MAXC];
  bit          e_done [2][MAXC];
  bit          e_err  [2][MAXC];
  logic [31:0] e_rd   [2][MAXC];
  bit          a_ack  [2][MAXC];
  logic [31:0] a_rd   [2][MAXC];

  int start [2];
  int drop  [2];
  bit r_we [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wd [2];

  int dreq_cnt = 0;
  int d0_cyc = -1, d1_cyc = -1;
  logic [31:0] d0_rd, d1_rd;
  logic d0_err, d1_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dev_req", dev_req, e_dreq[cyc]);
      if (e_dreq[cyc]) begin
        chk("dev_sel", dev_sel, e_sel[cyc]);
        chk("dev_addr", dev_addr, e_addr[cyc]);
        chk("dev_we", dev_we, e_we[cyc]);
        if (e_we[cyc]) chk("dev_wdata", dev_wdata, e_wd[cyc]);
      end
      chk("m0_done", m0_done, e_done[0][cyc]);
      if (e_done[0][cyc]) begin
        chk("m0_err", m0_err, e_err[0][cyc]);
        chk("m0_rdata", m0_rdata, e_rd[0][cyc]);
      end
      chk("m1_done", m1_done, e_done[1][cyc]);
      if (e_done[1][cyc]) begin
        chk("m1_err", m1_err, e_err[1][cyc]);
        chk("m1_rdata", m1_rdata, e_rd[1][cyc]);
      end
      chk("stall", stall, m0_req & ~e_done[0][cyc]);
    end
    if (dev_req) dreq_cnt++;
    if (m0_done) begin
      d0_cyc = cyc; d0_rd = m0_rdata; d0_err = m0_err;
    end
    if (m1_done) begin
      d1_cyc = cyc; d1_rd = m1_rdata; d1_err = m1_err;
    end
  end

  // One granted transaction: port p holds req from reqc,
  // wins arbitration in IDLE cycle n. ack_dly<0 = no ack.
  task automatic plan(input int p, input int reqc, input int n,
                      input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input int ack_dly,
                      input bit wrong, input logic [31:0] rd,
                      input int early, output int done);
    int d;
    int last;
    bit legal;
    logic [31:0] off;
    d = -1;
    off = 0;
    if (addr >= B0 && addr < B0 + 12) begin
      d = 0; off = addr - B0;
    end else if (addr >= B1 && addr < B1 + 12) begin
      d = 1; off = addr - B1;
    end
    legal = (d >= 0) && (addr % 4 == 0) && !(we && off == 8);
    if (!legal) begin
      done = n + 1;
      e_err[p][done] = 1;
      e_rd[p][done] = 0;
    end else begin
      last = (ack_dly >= 0) ? n + 1 + ack_dly : n + 1 + TMO;
      for (int c = n + 1; c <= last; c++) begin
        e_dreq[c] = 1;
        e_sel[c] = (d == 0) ? 2'b01 : 2'b10;
        e_addr[c] = 2'(off / 4);
        e_we[c] = we;
        e_wd[c] = wd;
      end
      done = last + 1;
      if (ack_dly >= 0) begin
        a_ack[d][last] = 1;
        a_rd[d][last] = rd;
        if (wrong) begin
          a_ack[1-d][last-1] = 1;
          a_rd[1-d][last-1] = 32'h5a5a_5a5a;
        end
        e_err[p][done] = 0;
        e_rd[p][done] = we ? 32'h0 : rd;
      end else begin
        e_err[p][done] = 1;
        e_rd[p][done] = 0;
      end
    end
    e_done[p][done] = 1;
    start[p] = reqc;
    drop[p] = (early > 0) ? n + early : done + 1;
    r_we[p] = we;
    r_addr[p] = addr;
    r_wd[p] = wd;
    mlast = p;
  endtask

  task automatic apply();
    if (cyc == start[0]) begin
      m0_req = 1; m0_we = r_we[0];
      m0_addr = r_addr[0]; m0_wdata = r_wd[0];
    end
    if (cyc == drop[0]) m0_req = 0;
    if (cyc == start[1]) begin
      m1_req = 1; m1_we = r_we[1];
      m1_addr = r_addr[1]; m1_wdata = r_wd[1];
    end
    if (cyc == drop[1]) m1_req = 0;
    dev0_ack = a_ack[0][cyc];
    dev1_ack = a_ack[1][cyc];
    dev0_rdata = a_ack[0][cyc] ? a_rd[0][cyc] : (32'h0bad_0000 | 32'(cyc));
    dev1_rdata = a_ack[1][cyc] ? a_rd[1][cyc] : (32'h0bad_1000 | 32'(cyc));
  endtask

  task automatic run_to(input int endc);
    while (cyc < endc) begin
      @(posedge clk);
      #1;
      apply();
    end
  endtask

  task automatic xact(input int p, input bit we,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int ack_dly, input bit wrong,
                      input logic [31:0] rd, input int early,
                      output int n);
    int d;
    n = cyc + 1;
    plan(p, n, n, we, addr, wd, ack_dly, wrong, rd, early, d);
    run_to(d + 1);
  endtask

  // Both ports request in cycle t; the port that did not
  // win last time goes first, the other right after.
  task automatic tie(input logic [31:0] a0, input logic [31:0] rd0,
                     input logic [31:0] a1, input logic [31:0] rd1,
                     output int t);
    int dw;
    int dl;
    t = cyc + 1;
    if (mlast == 1) begin
      plan(0, t, t, 0, a0, 0, 1, 0, rd0, 0, dw);
      plan(1, t, dw + 1, 0, a1, 0, 1, 0, rd1, 0, dl);
    end else begin
      plan(1, t, t, 0, a1, 0, 1, 0, rd1, 0, dw);
      plan(0, t, dw + 1, 0, a0, 0, 1, 0, rd0, 0, dl);
    end
    run_to(dl + 1);
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_dreq[i] = 0;
      e_done[0][i] = 0;
      e_done[1][i] = 0;
      a_ack[0][i] = 0;
      a_ack[1][i] = 0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    int dq;
    int d;
    reset = 1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    dev0_ack = 0; dev1_ack = 0;
    dev0_rdata = 0; dev1_rdata = 0;
    start[0] = -1; start[1] = -1;
    drop[0] = -1; drop[1] = -1;
    mlast = 1;
    #1 reset = 0;
    #1;
    chk("rst_dev_req", dev_req, 0);
    chk("rst_dev_sel", dev_sel, 0);
    chk("rst_m0_done", m0_done, 0);
    chk("rst_m1_done", m1_done, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_stall", stall, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1;
    chk_en = 1;

    tie(32'h7f00, 32'h1111, 32'h7f14, 32'h2222, t);
    chk("tie1_p0_cyc", d0_cyc, t + 3);
    chk("tie1_p1_cyc", d1_cyc, t + 7);
    chk("tie1_p1_rd", d1_rd, 32'h2222);

    xact(0, 0, 32'h7f04, 0, 2, 0, 32'h1234, 0, n);
    chk("t1_done_cyc", d0_cyc, n + 4);
    chk("t1_rdata", d0_rd, 32'h1234);
    chk("t1_err", d0_err, 0);

    xact(0, 1, 32'h7f18, 32'h55, -1, 0, 0, 0, n);
    chk("t2_count_cyc", d0_cyc, n + 1);
    chk("t2_count_err", d0_err, 1);
    xact(0, 1, 32'h7f12, 32'h66, -1, 0, 0, 0, n);
    chk("t2_unal_err", d0_err, 1);
    xact(0, 0, 32'h7f20, 0, -1, 0, 0, 0, n);
    chk("t2_out_err", d0_err, 1);
    xact(1, 0, 32'h7f0c, 0, -1, 0, 0, 0, n);
    chk("t2_gap_err", d1_err, 1);
    xact(0, 0, 32'h7f18, 0, 1, 0, 32'h0000_0042, 0, n);
    chk("count_rd", d0_rd, 32'h42);

    xact(1, 1, 32'h7f04, 32'hcafe, 2, 0, 32'h9999, 2, n);
    chk("wr_rdata0", d1_rd, 0);

    dq = dreq_cnt;
    xact(1, 0, 32'h7f00, 0, -1, 0, 0, 0, n);
    chk("t4_dreq_cycles", dreq_cnt - dq, 1 + 15);
    chk("t4_done_cyc", d1_cyc, n + 17);
    chk("t4_err", d1_err, 1);
    chk("t4_rdata", d1_rd, 0);

    xact(0, 0, 32'h7f10, 0, 3, 1, 32'hbeef, 0, n);
    chk("t5_rdata", d0_rd, 32'hbeef);
    chk("t5_done_cyc", d0_cyc, n + 5);

    tie(32'h7f08, 32'h3333, 32'h7f18, 32'h4444, t);
    chk("tie2_p1_first", d1_cyc, t + 3);
    chk("tie2_p0_rd", d0_rd, 32'h3333);

    n = cyc + 1;
    plan(0, n, n, 0, 32'h7f04, 0, -1, 0, 0, 0, d);
    run_to(n + 4);
    #2 reset = 0;
    #1;
    chk("t6_dev_req", dev_req, 0);
    chk("t6_dev_sel", dev_sel, 0);
    chk("t6_m0_done", m0_done, 0);
    chk("t6_m1_done", m1_done, 0);
    clear_from(n + 4);
    m0_req = 0;
    start[0] = -1;
    drop[0] = -1;
    mlast = 1;
    run_to(n + 6);
    reset = 1;
    tie(32'h7f00, 32'h7777, 32'h7f10, 32'h8888, t);
    chk("t6_p0_first", d0_cyc, t + 3);
    chk("t6_p0_rd", d0_rd, 32'h7777);

    run_to(cyc + 3);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
